// File: rtl/vram_dma.sv
// VRAM writer DMA: copies a block from the CPU shadow RAM into VRAM, or fills a
// VRAM region with a constant byte, issuing writes only while video timing allows.
module vram_dma #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  fill,
  input  logic [7:0]            fill_value,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  writable,
  output logic                  src_rd,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [7:0]            src_data,
  output logic                  vram_we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   ZERO_C = '0;

  state_t                r_state;
  logic                  r_fill;
  logic [ADDR_WIDTH-1:0] r_ptr_src;
  logic [ADDR_WIDTH-1:0] r_ptr_dst;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_src_rd;
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic [7:0]            r_data;
  logic                  r_busy;
  logic                  r_done;

  logic w_in_write;
  logic w_wr_fire;
  logic w_abort;
  logic w_last;

  // Handshake: start is a one-cycle request honoured only in IDLE; a shadow
  // read issued with src_rd returns src_data exactly one cycle later, and a
  // VRAM write happens in every cycle where vram_we is high.
  assign w_in_write = (r_state == S_WRITE);
  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_wr_fire  = w_in_write && writable && !abort;
  assign w_last     = (r_count == ONE_C);

  assign src_rd      = r_src_rd;
  assign src_addr    = r_src_addr;
  assign vram_we     = w_wr_fire;
  assign address     = r_ptr_dst;
  assign data        = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fill     <= 1'b0;
      r_ptr_src  <= '0;
      r_ptr_dst  <= '0;
      r_count    <= '0;
      r_src_rd   <= 1'b0;
      r_src_addr <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_src_rd <= 1'b0;
      r_done   <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_fill    <= fill;
              r_ptr_src <= src_base;
              r_ptr_dst <= dst_base;
              r_count   <= length;
              r_busy    <= 1'b1;
              if (length == ZERO_C) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (fill) begin
                r_state <= S_WRITE;
                r_data  <= fill_value;
              end else begin
                r_state    <= S_READ;
                r_src_rd   <= 1'b1;
                r_src_addr <= src_base;
              end
            end
          end
          S_READ: begin
            r_state <= S_LATCH;
          end
          S_LATCH: begin
            r_data  <= src_data;
            r_state <= S_WRITE;
          end
          S_WRITE: begin
            // Stalled writes leave pointers, count and data untouched.
            if (writable) begin
              r_ptr_dst <= r_ptr_dst + ONE_A;
              r_ptr_src <= r_ptr_src + ONE_A;
              r_count   <= r_count - ONE_C;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (!r_fill) begin
                r_state    <= S_READ;
                r_src_rd   <= 1'b1;
                r_src_addr <= r_ptr_src + ONE_A;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Writer side of the GPU VRAM write interface (`data`, `address`, plus write strobe).
- On a `start` pulse, copies a block of bytes from a CPU-side shadow RAM into VRAM, or fills a VRAM region with a constant.
- Issues writes only while the video timing reports `writable` (blanking), so no write collides with active scan-out.
- Sits between the CPU bus/shadow RAM and the GPU's VRAM inputs.

Parameters:
- ADDR_WIDTH, 12, VRAM and shadow address width; instantiated equal to `VRAM_ADDR_WIDTH`.

Ports:
- clk  in  1  pixel clock (12.5875 MHz).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  cancels any transfer.
- fill  in  1  mode, latched at start: 1 = constant fill, 0 = copy.
- fill_value  in  8  fill byte, latched at start.
- src_base  in  ADDR_WIDTH  shadow start address, latched at start.
- dst_base  in  ADDR_WIDTH  VRAM start address, latched at start.
- length  in  ADDR_WIDTH+1  byte count, 0..2^ADDR_WIDTH, latched at start.
- writable  in  1  from video timing; high when VRAM may be written.
- src_rd  out  1  shadow read enable.
- src_addr  out  ADDR_WIDTH  shadow read address.
- src_data  in  8  shadow read data; valid exactly 1 cycle after `src_rd`.
- vram_we  out  1  VRAM write strobe.
- address  out  ADDR_WIDTH  VRAM write address.
- data  out  8  VRAM write data.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, any state): state = IDLE. All outputs 0, including `busy`, `done`, `vram_we`, `src_rd`, `src_addr`, `address` and `data`. Internal pointers and count are cleared.
- States: IDLE, READ, LATCH, WRITE, DONE. All state and output registers change on the rising edge of `clk`.
- IDLE + `start`: latch mode and operands.
  - `ptr_src` = `src_base`, `ptr_dst` = `dst_base`, `count` = `length`.
  - If `length` == 0, go to DONE.
  - Else, if `fill`, go to WRITE with `data` = `fill_value`.
  - Else go to READ.
- READ: `src_rd` = 1 and `src_addr` = `ptr_src` for exactly this cycle. Next state is LATCH.
- LATCH: capture `src_data` into the `data` register. Next state is WRITE.
- WRITE: `vram_we` = `writable`, combinational from state and `writable`. `address` = `ptr_dst`.
  - If `writable` is low: hold WRITE; `data`, `address` and `count` are unchanged.
  - If `writable` is high: `ptr_dst`+1, `ptr_src`+1, `count`−1.
  - After that update, if `count` reaches 0, go to DONE.
  - Else, in fill mode, stay in WRITE (one byte per writable cycle).
  - Else, in copy mode, go to READ (one byte per 3 cycles).
- Address arithmetic: pointers wrap modulo 2^ADDR_WIDTH; no error is flagged on wrap.
- DONE: `done` = 1 for one cycle, then go to IDLE. `busy` deasserts in the cycle after DONE.
- `busy` = 1 in READ, LATCH, WRITE and DONE.
- `start` while not IDLE: ignored; the latched operands do not change.
- `abort` (any non-IDLE state): go to IDLE on the next edge.
  - `vram_we` is forced 0 in the abort cycle.
  - No `done` pulse.
  - A write already strobed in an earlier cycle is not undone.
- `abort` and `start` together in IDLE: abort wins; the start is dropped.
- `writable` falling mid-transfer: the transfer stalls in WRITE and resumes when `writable` rises again.
- READ/LATCH proceed regardless of `writable`.
- `length` = 2^ADDR_WIDTH: writes the entire VRAM exactly once.

Test Plan:
- Copy: shadow[0x100..0x103] = A0,A1,A2,A3; `src_base`=0x100, `dst_base`=0x040, `length`=4, `writable`=1 → exactly 4 `vram_we` pulses, `address` 0x040..0x043 with `data` A0..A3, 3 cycles apart. `done` pulses once after the last write; `busy` low the following cycle.
- Fill with stall: `fill`=1, `fill_value`=0x55, `dst_base`=0x000, `length`=8; `writable` toggles 3 cycles high / 3 cycles low → exactly 8 writes of 0x55 to 0x000..0x007, none while `writable`=0, `done` after the 8th write.
- Wrap: `dst_base` = 2^ADDR_WIDTH−2, `length`=4, fill 0xFF → writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Zero length: `length`=0 → no `vram_we`, no `src_rd`; `done` pulses 1 cycle after start.
- Abort and restart: start a copy with `length`=16, assert `abort` after the 5th write → `vram_we` low in the abort cycle, no `done`, IDLE next cycle. A new start then completes normally; a start issued during the busy window is ignored.
- Async reset mid-WRITE (`vram_we` high): all outputs 0 immediately without waiting for a clock edge; no writes after reset release until a new start.
